// File: rtl/mc_control_fsm_if.sv
// rtl/mc_control_fsm_if.sv - control/datapath bundle between the multi-cycle control FSM and its datapath
interface mc_control_fsm_if #(
  parameter int OP_W = 6
);
  logic [OP_W-1:0] opcode;
  logic [OP_W-1:0] funct;
  logic            zero;
  logic            pc_write_en;
  logic [1:0]      pc_src;
  logic            i_or_d;
  logic            mem_read;
  logic            mem_write;
  logic            ir_write;
  logic            reg_write;
  logic            reg_dst;
  logic            mem_to_reg;
  logic            alu_src_a;
  logic [1:0]      alu_src_b;
  logic [2:0]      alu_sel;

  // Control FSM side: reads instruction fields and the ALU flag, drives strobes
  modport master (
    input  opcode, funct, zero,
    output pc_write_en, pc_src, i_or_d, mem_read, mem_write, ir_write,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_sel
  );

  // Datapath side
  modport slave (
    output opcode, funct, zero,
    input  pc_write_en, pc_src, i_or_d, mem_read, mem_write, ir_write,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_sel
  );
endinterface

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multi-cycle CPU main control FSM (optional ILLEGAL_TRAP_EN makes ILLEGAL a halting sink)
module mc_control_fsm #(
  parameter int CNT_W = 32,
  parameter int OP_W  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  mc_control_fsm_if.master ctrl,
  output logic [3:0]       state_dbg,
  output logic [CNT_W-1:0] instr_count,
  output logic             halted
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_R_EXEC    = 4'd3,
    S_R_WB      = 4'd4,
    S_MEM_ADDR  = 4'd5,
    S_MEM_READ  = 4'd6,
    S_MEM_WB    = 4'd7,
    S_MEM_WRITE = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_I_EXEC    = 4'd11,
    S_I_WB      = 4'd12,
    S_ILLEGAL   = 4'd13
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b010;
  localparam logic [2:0] ALU_SRL = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_AND = 3'b110;
  localparam logic [2:0] ALU_XOR = 3'b111;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             halted_q, halted_d;
  logic             bne_q, bne_d;
  logic             branch_q, branch_d;
  logic             pc_write_q, pc_write_d;
  logic [1:0]       pc_src_q, pc_src_d;
  logic             i_or_d_q, i_or_d_d;
  logic             mem_read_q, mem_read_d;
  logic             mem_write_q, mem_write_d;
  logic             ir_write_q, ir_write_d;
  logic             reg_write_q, reg_write_d;
  logic             reg_dst_q, reg_dst_d;
  logic             mem_to_reg_q, mem_to_reg_d;
  logic             alu_src_a_q, alu_src_a_d;
  logic [1:0]       alu_src_b_q, alu_src_b_d;
  logic [2:0]       alu_sel_q, alu_sel_d;

  logic             r_ok;
  logic [2:0]       r_sel;
  logic [2:0]       i_sel;
  logic             retire;

  // Next state, retirement counting and Moore outputs decoded from the next state so they register alongside it
  always_comb begin
    r_ok  = 1'b1;
    r_sel = ALU_ADD;
    case (ctrl.funct)
      6'b100000: r_sel = ALU_ADD;
      6'b100010: r_sel = ALU_SUB;
      6'b101010: r_sel = ALU_SLT;
      6'b000010: r_sel = ALU_SRL;
      6'b000000: r_sel = ALU_SLL;
      6'b100101: r_sel = ALU_OR;
      6'b100100: r_sel = ALU_AND;
      6'b100110: r_sel = ALU_XOR;
      default:   r_ok  = 1'b0;
    endcase

    i_sel = ALU_ADD;
    case (ctrl.opcode)
      OP_ORI:  i_sel = ALU_OR;
      OP_ANDI: i_sel = ALU_AND;
      OP_SLTI: i_sel = ALU_SLT;
      default: i_sel = ALU_ADD;
    endcase

    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (ctrl.opcode)
          OP_RTYPE:                          state_d = S_R_EXEC;
          OP_LW, OP_SW:                      state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
          OP_J:                              state_d = S_JUMP;
          OP_ADDI, OP_ORI, OP_ANDI, OP_SLTI: state_d = S_I_EXEC;
          default:                           state_d = S_ILLEGAL;
        endcase
      end
      S_R_EXEC:   state_d = r_ok ? S_R_WB : S_ILLEGAL;
      S_MEM_ADDR: state_d = (ctrl.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: state_d = S_MEM_WB;
      S_I_EXEC:   state_d = S_I_WB;
      S_R_WB, S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JUMP, S_I_WB: state_d = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_ILLEGAL:  state_d = S_ILLEGAL;
`else
      S_ILLEGAL:  state_d = S_FETCH;
`endif
      default:    state_d = S_IDLE;
    endcase

    // An illegal instruction counts as a retired NOP unless it traps
    retire = (state_q == S_R_WB)   || (state_q == S_MEM_WB) || (state_q == S_MEM_WRITE) ||
             (state_q == S_BRANCH) || (state_q == S_JUMP)   || (state_q == S_I_WB);
`ifndef ILLEGAL_TRAP_EN
    retire = retire || (state_q == S_ILLEGAL);
`endif
    count_d = count_q + {{(CNT_W-1){1'b0}}, retire};

`ifdef ILLEGAL_TRAP_EN
    halted_d = (state_d == S_ILLEGAL);
`else
    halted_d = 1'b0;
`endif

    // Branch sense is captured on entry so the zero test needs no opcode in BRANCH
    bne_d        = (ctrl.opcode == OP_BNE);
    branch_d     = 1'b0;
    pc_write_d   = 1'b0;
    pc_src_d     = 2'b00;
    i_or_d_d     = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    ir_write_d   = 1'b0;
    reg_write_d  = 1'b0;
    reg_dst_d    = 1'b0;
    mem_to_reg_d = 1'b0;
    alu_src_a_d  = 1'b0;
    alu_src_b_d  = 2'b00;
    alu_sel_d    = ALU_ADD;
    case (state_d)
      S_FETCH: begin
        mem_read_d  = 1'b1;
        ir_write_d  = 1'b1;
        alu_src_b_d = 2'b01;
        pc_write_d  = 1'b1;
      end
      S_DECODE:    alu_src_b_d = 2'b11;
      S_R_EXEC: begin
        alu_src_a_d = 1'b1;
        alu_sel_d   = r_sel;
      end
      S_R_WB: begin
        reg_write_d = 1'b1;
        reg_dst_d   = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'b10;
      end
      S_MEM_READ: begin
        mem_read_d = 1'b1;
        i_or_d_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_d  = 1'b1;
        mem_to_reg_d = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write_d = 1'b1;
        i_or_d_d    = 1'b1;
      end
      S_BRANCH: begin
        branch_d    = 1'b1;
        alu_src_a_d = 1'b1;
        alu_sel_d   = ALU_SUB;
        pc_src_d    = 2'b01;
      end
      S_JUMP: begin
        pc_src_d   = 2'b10;
        pc_write_d = 1'b1;
      end
      S_I_EXEC: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'b10;
        alu_sel_d   = i_sel;
      end
      S_I_WB:      reg_write_d = 1'b1;
      default:     ;
    endcase
  end

  // State register and registered control outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      halted_q     <= 1'b0;
      bne_q        <= 1'b0;
      branch_q     <= 1'b0;
      pc_write_q   <= 1'b0;
      pc_src_q     <= 2'b00;
      i_or_d_q     <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      ir_write_q   <= 1'b0;
      reg_write_q  <= 1'b0;
      reg_dst_q    <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_src_a_q  <= 1'b0;
      alu_src_b_q  <= 2'b00;
      alu_sel_q    <= ALU_ADD;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      halted_q     <= halted_d;
      bne_q        <= bne_d;
      branch_q     <= branch_d;
      pc_write_q   <= pc_write_d;
      pc_src_q     <= pc_src_d;
      i_or_d_q     <= i_or_d_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      ir_write_q   <= ir_write_d;
      reg_write_q  <= reg_write_d;
      reg_dst_q    <= reg_dst_d;
      mem_to_reg_q <= mem_to_reg_d;
      alu_src_a_q  <= alu_src_a_d;
      alu_src_b_q  <= alu_src_b_d;
      alu_sel_q    <= alu_sel_d;
    end
  end

  // Branch PC write is the only output that looks at zero in the current cycle
  assign ctrl.pc_write_en = pc_write_q | (branch_q & (bne_q ? ~ctrl.zero : ctrl.zero));
  assign ctrl.pc_src      = pc_src_q;
  assign ctrl.i_or_d      = i_or_d_q;
  assign ctrl.mem_read    = mem_read_q;
  assign ctrl.mem_write   = mem_write_q;
  assign ctrl.ir_write    = ir_write_q;
  assign ctrl.reg_write   = reg_write_q;
  assign ctrl.reg_dst     = reg_dst_q;
  assign ctrl.mem_to_reg  = mem_to_reg_q;
  assign ctrl.alu_src_a   = alu_src_a_q;
  assign ctrl.alu_src_b   = alu_src_b_q;
  assign ctrl.alu_sel     = alu_sel_q;
  assign state_dbg        = state_q;
  assign instr_count      = count_q;
  assign halted           = halted_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - self-checking bench for mc_control_fsm (honours ILLEGAL_TRAP_EN when defined)
module tb_mc_control_fsm;
  localparam int CW = 4;

  typedef enum {P_IDLE, P_FETCH, P_DECODE, P_R_EXEC, P_R_WB, P_MEM_ADDR, P_MEM_READ,
                P_MEM_WB, P_MEM_WRITE, P_BRANCH, P_JUMP, P_I_EXEC, P_I_WB, P_ILLEGAL} phase_t;
  typedef phase_t phase_q_t[$];

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [3:0]    state_dbg;
  logic [CW-1:0] instr_count;
  logic          halted;
  int            checks = 0;
  int            failures = 0;
  int            model_count = 0;

  always #5 clk = ~clk;

  mc_control_fsm_if ctrl_if ();

  mc_control_fsm #(.CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ctrl        (ctrl_if.master),
    .state_dbg   (state_dbg),
    .instr_count (instr_count),
    .halted      (halted)
  );

  function automatic logic [15:0] pk(input logic pcw, input logic [1:0] ps, input logic iod,
                                     input logic mr, input logic mw, input logic irw,
                                     input logic rw, input logic rd, input logic m2r,
                                     input logic sa, input logic [1:0] sb, input logic [2:0] sel);
    return {pcw, ps, iod, mr, mw, irw, rw, rd, m2r, sa, sb, sel};
  endfunction

  function automatic logic [15:0] obs_vec();
    return {ctrl_if.pc_write_en, ctrl_if.pc_src, ctrl_if.i_or_d, ctrl_if.mem_read,
            ctrl_if.mem_write, ctrl_if.ir_write, ctrl_if.reg_write, ctrl_if.reg_dst,
            ctrl_if.mem_to_reg, ctrl_if.alu_src_a, ctrl_if.alu_src_b, ctrl_if.alu_sel};
  endfunction

  function automatic int r_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 0;
      6'b100010: return 1;
      6'b101010: return 2;
      6'b000010: return 3;
      6'b000000: return 4;
      6'b100101: return 5;
      6'b100100: return 6;
      6'b100110: return 7;
      default:   return -1;
    endcase
  endfunction

  function automatic logic [2:0] i_alu(input logic [5:0] opc);
    case (opc)
      6'b001101: return 3'd5;
      6'b001100: return 3'd6;
      6'b001010: return 3'd2;
      default:   return 3'd0;
    endcase
  endfunction

  function automatic bit is_illegal(input logic [5:0] opc, input logic [5:0] fn);
    case (opc)
      6'b000000: return r_alu(fn) < 0;
      6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010,
      6'b001000, 6'b001101, 6'b001100, 6'b001010: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // Sequence of states an instruction walks through, taken from the instruction class
  function automatic phase_q_t phases(input logic [5:0] opc, input logic [5:0] fn);
    phase_q_t q;
    q.push_back(P_FETCH);
    q.push_back(P_DECODE);
    case (opc)
      6'b000000: begin q.push_back(P_R_EXEC); q.push_back(r_alu(fn) >= 0 ? P_R_WB : P_ILLEGAL); end
      6'b100011: begin q.push_back(P_MEM_ADDR); q.push_back(P_MEM_READ); q.push_back(P_MEM_WB); end
      6'b101011: begin q.push_back(P_MEM_ADDR); q.push_back(P_MEM_WRITE); end
      6'b000100, 6'b000101: q.push_back(P_BRANCH);
      6'b000010: q.push_back(P_JUMP);
      6'b001000, 6'b001101, 6'b001100, 6'b001010: begin q.push_back(P_I_EXEC); q.push_back(P_I_WB); end
      default: q.push_back(P_ILLEGAL);
    endcase
    return q;
  endfunction

  function automatic logic [15:0] expect_out(input phase_t p, input logic [5:0] opc,
                                             input logic [5:0] fn, input logic z);
    int s;
    case (p)
      P_FETCH:     return pk(1, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 3'd0);
      P_DECODE:    return pk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'd0);
      P_R_EXEC: begin
        s = r_alu(fn);
        return pk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, (s < 0) ? 3'd0 : 3'(s));
      end
      P_R_WB:      return pk(0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 3'd0);
      P_MEM_ADDR:  return pk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'd0);
      P_MEM_READ:  return pk(0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'd0);
      P_MEM_WB:    return pk(0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'd0);
      P_MEM_WRITE: return pk(0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 3'd0);
      P_BRANCH:    return pk((opc == 6'b000101) ? !z : z, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'd1);
      P_JUMP:      return pk(1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'd0);
      P_I_EXEC:    return pk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, i_alu(opc));
      P_I_WB:      return pk(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 3'd0);
      default:     return 16'h0000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one instruction; zmode<0 randomises zero each cycle. abort_step>=0 pulses reset after that step.
  task automatic run_instr(input logic [5:0] opc, input logic [5:0] fn, input int zmode, input int abort_step);
    phase_q_t pq;
    logic z;
    pq = phases(opc, fn);
    foreach (pq[k]) begin
      @(negedge clk);
      z = (zmode < 0) ? 1'($urandom) : 1'(zmode);
      ctrl_if.zero = z;
      #1;
      if (k == 0) begin
        chk($sformatf("count_at_fetch op%b", opc), 32'(instr_count), 32'(model_count));
        chk($sformatf("halted_at_fetch op%b", opc), 32'(halted), 32'd0);
      end
      chk($sformatf("op%b fn%b step%0d", opc, fn, k), 32'(obs_vec()), 32'(expect_out(pq[k], opc, fn, z)));
      chk($sformatf("rd_wr_excl op%b step%0d", opc, k), 32'(ctrl_if.mem_read & ctrl_if.mem_write), 32'd0);
      if (k == 0) begin
        ctrl_if.opcode = opc;
        ctrl_if.funct  = fn;
      end
      if (k == abort_step) begin
        #1 rst_n = 1'b0;
        #1;
        model_count = 0;
        chk("abort_outputs", 32'(obs_vec()), 32'd0);
        chk("abort_count", 32'(instr_count), 32'd0);
        chk("abort_halted", 32'(halted), 32'd0);
        return;
      end
    end
`ifdef ILLEGAL_TRAP_EN
    if (!is_illegal(opc, fn)) model_count = (model_count + 1) % (1 << CW);
`else
    model_count = (model_count + 1) % (1 << CW);
`endif
  endtask

  initial begin
    logic [5:0] r_fn [8];
    int pick;
    logic [5:0] opc, fn;
    r_fn = '{6'b100000, 6'b100010, 6'b101010, 6'b000010, 6'b000000, 6'b100101, 6'b100100, 6'b100110};
    ctrl_if.opcode = 6'd0;
    ctrl_if.funct  = 6'd0;
    ctrl_if.zero   = 1'b0;

    #2 rst_n = 1'b0;
    #2;
    chk("reset_outputs", 32'(obs_vec()), 32'd0);
    chk("reset_count", 32'(instr_count), 32'd0);
    chk("reset_halted", 32'(halted), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("idle_outputs", 32'(obs_vec()), 32'd0);

    run_instr(6'b000000, 6'b100000, -1, -1);   // add
    run_instr(6'b100011, 6'b010101, -1, -1);   // lw
    run_instr(6'b000100, 6'b000000, 1, -1);    // beq taken
    run_instr(6'b000101, 6'b000000, 1, -1);    // bne not taken
    run_instr(6'b001010, 6'b000000, -1, -1);   // slti

    for (int n = 0; n < 40; n++) begin
`ifdef ILLEGAL_TRAP_EN
      pick = $urandom_range(0, 17);
      if (pick == 8) pick = 0;
`else
      pick = $urandom_range(0, 18);
`endif
      fn = 6'($urandom);
      case (pick)
        0, 1, 2, 3, 4, 5, 6, 7: begin opc = 6'b000000; fn = r_fn[pick]; end
        8:  begin opc = 6'b000000; fn = 6'b111111; end
        9:  opc = 6'b100011;
        10: opc = 6'b101011;
        11: opc = 6'b000100;
        12: opc = 6'b000101;
        13: opc = 6'b000010;
        14: opc = 6'b001000;
        15: opc = 6'b001101;
        16: opc = 6'b001100;
        17: opc = 6'b001010;
        default: opc = 6'b111111;
      endcase
      run_instr(opc, fn, -1, -1);
    end

    run_instr(6'b111111, 6'b000000, -1, -1);
`ifdef ILLEGAL_TRAP_EN
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("trap_halted c%0d", c), 32'(halted), 32'd1);
      chk($sformatf("trap_outputs c%0d", c), 32'(obs_vec()), 32'd0);
      chk($sformatf("trap_count c%0d", c), 32'(instr_count), 32'(model_count));
    end
`endif

    run_instr(6'b100011, 6'b000000, -1, 3);    // reset during MEM_READ
    @(negedge clk);
    chk("held_reset_outputs", 32'(obs_vec()), 32'd0);
    rst_n = 1'b1;
    #1 chk("idle_after_abort", 32'(obs_vec()), 32'd0);
    run_instr(6'b000010, 6'b000000, -1, -1);   // j
    run_instr(6'b101011, 6'b000000, -1, -1);   // sw
    @(negedge clk);
    #1 chk("final_count", 32'(instr_count), 32'(model_count));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Main control state machine of the multi-cycle CPU. It sits directly upstream of the ALU and generates the 3-bit ALU operation select, the ALU operand-mux selects and every datapath strobe (PC, memory, IR, register file) for one instruction at a time. Control outputs are Moore-decoded from the state register, except the branch PC write, which also qualifies on the ALU zero flag.

Parameters:
CNT_W, 32, width of the retired-instruction counter
OP_W, 6, opcode and funct field width (fixed by the ISA; not meant to be overridden)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26], valid from DECODE onward
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag (ALU computes it for SUB only)
pc_write_en  out  1  PC load enable: unconditional write OR (branch condition AND its zero test)
pc_src  out  2  PC mux select: 00 = ALU result, 01 = ALUOut, 10 = jump target
i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  instruction register load
reg_write  out  1  register-file write
reg_dst  out  1  destination select: 0 = rt, 1 = rd
mem_to_reg  out  1  write-back select: 0 = ALUOut, 1 = MDR
alu_src_a  out  1  ALU A select: 0 = PC, 1 = register A
alu_src_b  out  2  ALU B select: 00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2
alu_sel  out  3  ALU op: 000 ADD, 001 SUB, 010 SLT, 011 SRL, 100 SLL, 101 OR, 110 AND, 111 XOR
state_dbg  out  4  current state encoding
instr_count  out  CNT_W  retired-instruction counter
halted  out  1  trap indicator (see Optional Feature)

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE, instr_count = 0, halted = 0. All strobes are 0, pc_src/alu_src_a/alu_src_b = 0, alu_sel = 000.
- IDLE: all strobes 0. Moves to FETCH on the first clk after rst_n deasserts.
- FETCH: mem_read = 1, ir_write = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, ADD, pc_src = 00, pc_write_en = 1. Next state: DECODE.
- DECODE: alu_src_a = 0, alu_src_b = 11, ADD (branch target into ALUOut). Next state by opcode:
  - 000000 -> R_EXEC
  - 100011 / 101011 -> MEM_ADDR
  - 000100 / 000101 -> BRANCH
  - 000010 -> JUMP
  - 001000 / 001101 / 001100 / 001010 -> I_EXEC
  - other -> ILLEGAL
- R_EXEC: alu_src_a = 1, alu_src_b = 00, alu_sel from funct:
  - 100000 ADD, 100010 SUB, 101010 SLT, 000010 SRL, 000000 SLL, 100101 OR, 100100 AND, 100110 XOR
  - other funct -> ILLEGAL, no write-back.
  - Next state: R_WB.
- R_WB: reg_write = 1, reg_dst = 1, mem_to_reg = 0. Instruction retires; next state FETCH.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, ADD. lw -> MEM_READ, sw -> MEM_WRITE.
- MEM_READ: mem_read = 1, i_or_d = 1. Next state: MEM_WB.
- MEM_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 1. Retires.
- MEM_WRITE: mem_write = 1, i_or_d = 1. Retires.
- BRANCH: alu_src_a = 1, alu_src_b = 00, SUB, pc_src = 01.
  - pc_write_en = zero for beq, !zero for bne (combinational on zero within the cycle).
  - Retires.
- JUMP: pc_src = 10, pc_write_en = 1. Retires.
- I_EXEC: alu_src_a = 1, alu_src_b = 10. addi ADD, ori OR, andi AND, slti SLT. Next state: I_WB.
- I_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 0. Retires.
- Latencies:
  - R-type, sw, I-type: 4 cycles
  - lw: 5 cycles
  - beq, bne, j: 3 cycles
- instr_count increments by 1 on the clock edge that leaves a retiring state, and wraps modulo 2^CNT_W.
- mem_read and mem_write are never asserted in the same cycle.
- reg_write is asserted only in R_WB, MEM_WB and I_WB.
- Reset mid-instruction aborts it immediately, returns to IDLE and clears instr_count; no strobes are issued after reset assertion.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: ILLEGAL is a sink state. halted = 1, all strobes 0, and the FSM leaves ILLEGAL only via reset.
- Undefined: ILLEGAL lasts one cycle with all strobes 0, then goes to FETCH. The instruction is treated as a NOP: it is counted as retired and halted stays 0.

Test Plan:
- Reset release, then add (opcode 000000, funct 100000): state sequence IDLE, FETCH, DECODE, R_EXEC (alu_sel 000), R_WB (reg_write 1, reg_dst 1); instr_count 0 -> 1.
- lw (100011): 5 cycles; MEM_READ has mem_read 1 and i_or_d 1; MEM_WB has mem_to_reg 1; mem_write stays 0 throughout.
- beq (000100) with zero = 1: pc_write_en 1 and pc_src 01 in BRANCH. bne with zero = 1: pc_write_en 0 in BRANCH.
- slti (001010): I_EXEC alu_sel 010, alu_src_b 10; I_WB reg_write 1, reg_dst 0.
- Opcode 111111 with ILLEGAL_TRAP_EN defined: halted 1 and strobes 0 for 10+ cycles. Undefined: back to FETCH after 1 cycle, instr_count +1.
- rst_n pulsed low during MEM_READ: outputs go to reset values asynchronously and instr_count = 0; after release, FETCH follows IDLE.
